// File: rtl/cpu_alu_seq_if.sv
// Execute-stage handshake bundle between the CPU control unit (master) and the sequential ALU (slave).
// Carries the operand channel (in_*), the result channel (out_*) and the Z/N/C/V flags.
interface cpu_alu_seq_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [3:0]            op_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  z_flag;
    logic                  n_flag;
    logic                  c_flag;
    logic                  v_flag;

    modport master (
        output in_valid, in_a, in_b, op_sel, out_ready,
        input  in_ready, out_valid, alu_out, z_flag, n_flag, c_flag, v_flag
    );

    modport slave (
        input  in_valid, in_a, in_b, op_sel, out_ready,
        output in_ready, out_valid, alu_out, z_flag, n_flag, c_flag, v_flag
    );
endinterface

// File: rtl/cpu_alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, with valid/ready handshakes and Z/N/C/V flags.
module cpu_alu_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cpu_alu_seq_if.slave  bus
);
    localparam int unsigned DW      = DATA_WIDTH;
    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [DW-1:0]       a_q;
    logic [DW-1:0]       b_q;
    logic [2*DW-1:0]     work;
    logic [SHAMT_W-1:0]  cnt;

    // Single-cycle datapath, evaluated on the live operands at acceptance
    logic [DW:0]         add_w;
    logic [DW:0]         sub_w;
    logic [SHAMT_W-1:0]  shamt;
    logic [DW-1:0]       sc_res;
    logic                sc_c;
    logic                sc_v;
    logic                sc_iter;
    logic                sc_div;

    always_comb begin
        add_w   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        sub_w   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        shamt   = bus.in_b[SHAMT_W-1:0];
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_iter = (bus.op_sel >= OP_MUL) && (bus.op_sel <= OP_REMU);
        sc_div  = (bus.op_sel == OP_DIVU) || (bus.op_sel == OP_REMU);
        case (bus.op_sel)
            OP_ADD: begin
                sc_res = add_w[DW-1:0];
                sc_c   = add_w[DW];
                sc_v   = (bus.in_a[DW-1] == bus.in_b[DW-1]) && (add_w[DW-1] != bus.in_a[DW-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[DW-1:0];
                sc_c   = sub_w[DW];
                sc_v   = (bus.in_a[DW-1] != bus.in_b[DW-1]) && (sub_w[DW-1] != bus.in_a[DW-1]);
            end
            OP_AND:  sc_res = bus.in_a & bus.in_b;
            OP_OR:   sc_res = bus.in_a | bus.in_b;
            OP_XOR:  sc_res = bus.in_a ^ bus.in_b;
            OP_SLT:  sc_res = {{(DW-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_SLTU: sc_res = {{(DW-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_SLL:  sc_res = bus.in_a << shamt;
            OP_SRL:  sc_res = bus.in_a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.in_a) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    // One iteration step; work holds {acc, multiplier} for MUL or {remainder, dividend/quotient} for DIV
    logic [DW:0]         mul_sum;
    logic [DW:0]         rem_sh;
    logic [DW-1:0]       rem_diff;
    logic                rem_ge;
    logic [2*DW-1:0]     step_next;
    logic [DW-1:0]       iter_res;

    always_comb begin
        mul_sum  = {1'b0, work[2*DW-1:DW]} + (work[0] ? {1'b0, a_q} : {(DW+1){1'b0}});
        rem_sh   = {work[2*DW-1:DW], work[DW-1]};
        rem_diff = rem_sh[DW-1:0] - b_q;
        rem_ge   = (rem_sh >= {1'b0, b_q});
        if ((op_q == OP_DIVU) || (op_q == OP_REMU)) begin
            step_next = rem_ge ? {rem_diff, work[DW-2:0], 1'b1}
                               : {rem_sh[DW-1:0], work[DW-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, work[DW-1:1]};
        end
        case (op_q)
            OP_MUL, OP_DIVU: iter_res = step_next[DW-1:0];
            default:         iter_res = step_next[2*DW-1:DW];
        endcase
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            work          <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.alu_out   <= '0;
            bus.z_flag    <= 1'b0;
            bus.n_flag    <= 1'b0;
            bus.c_flag    <= 1'b0;
            bus.v_flag    <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        op_q         <= bus.op_sel;
                        a_q          <= bus.in_a;
                        b_q          <= bus.in_b;
                        cnt          <= '0;
                        if (sc_iter) begin
                            work  <= sc_div ? {DW'(0), bus.in_a} : {DW'(0), bus.in_b};
                            state <= BUSY;
                        end else begin
                            bus.alu_out   <= sc_res;
                            bus.z_flag    <= (sc_res == '0);
                            bus.n_flag    <= sc_res[DW-1];
                            bus.c_flag    <= sc_c;
                            bus.v_flag    <= sc_v;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                BUSY: begin
                    work <= step_next;
                    if (cnt == CNT_LAST) begin
                        cnt           <= '0;
                        bus.alu_out   <= iter_res;
                        bus.z_flag    <= (iter_res == '0);
                        bus.n_flag    <= iter_res[DW-1];
                        bus.c_flag    <= 1'b0;
                        bus.v_flag    <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + SHAMT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq: directed corner cases at 32 bits, then random ops at 32 and 16 bits
// checked against an arithmetic reference model.
module tb_cpu_alu_seq;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cpu_alu_seq_if #(.DATA_WIDTH(32)) bus32 ();
    cpu_alu_seq_if #(.DATA_WIDTH(16)) bus16 ();

    cpu_alu_seq #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32.slave));
    cpu_alu_seq #(.DATA_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .flush(flush), .bus(bus16.slave));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {z, n, c, v}
        int          lat;
    } dvec_t;

    function automatic longint sx(input longint unsigned x, input int unsigned w);
        if (((x >> (w - 1)) & 64'd1) != 0) return $signed(x) - (longint'(1) << w);
        return $signed(x);
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on 64-bit values, masked to width w
    function automatic void ref_op(input int unsigned w, input logic [3:0] op,
                                   input longint unsigned a, input longint unsigned b,
                                   output longint unsigned res, output logic [3:0] fl, output int lat);
        longint unsigned mask, full;
        longint sa, sb, s, smax, smin;
        int unsigned sh;
        logic c, v;
        mask = (64'd1 << w) - 64'd1;
        sa = sx(a, w);
        sb = sx(b, w);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sh = int'(b % longint'(w));
        c = 1'b0; v = 1'b0; lat = 1; res = 0;
        case (op)
            4'd0: begin full = a + b; res = full & mask; c = (full >> w) != 0;
                        s = sa + sb; v = (s > smax) || (s < smin); end
            4'd1: begin res = (a - b) & mask; c = a < b;
                        s = sa - sb; v = (s > smax) || (s < smin); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (sa < sb) ? 1 : 0;
            4'd6: res = (a < b) ? 1 : 0;
            4'd7: res = (a << sh) & mask;
            4'd8: res = a >> sh;
            4'd9: res = $unsigned(sa >>> sh) & mask;
            4'd10: begin res = (a * b) & mask; lat = w + 1; end
            4'd11: begin res = (a * b) >> w; lat = w + 1; end
            4'd12: begin res = (b == 0) ? mask : a / b; lat = w + 1; end
            4'd13: begin res = (b == 0) ? a : a % b; lat = w + 1; end
            default: res = 0;
        endcase
        fl = {res == 0, ((res >> (w - 1)) & 64'd1) != 0, c, v};
    endfunction

    function automatic longint unsigned pick(input int unsigned w);
        longint unsigned mask, r;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       r = 0;
            1:       r = mask;
            2:       r = 64'd1 << (w - 1);
            3:       r = $urandom_range(0, 15);
            default: r = {$urandom, $urandom} & mask;
        endcase
        return r;
    endfunction

    // Full transaction on the 32-bit instance; call and return at a falling edge
    task automatic do_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [3:0] fl, output int lat,
                           output bit leak, output bit tmo);
        int guard = 0;
        tmo = 0; leak = 0;
        while (!bus32.in_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!bus32.in_ready) tmo = 1;
        bus32.in_valid = 1'b1; bus32.op_sel = op; bus32.in_a = a; bus32.in_b = b;
        @(posedge clk); #1 bus32.in_valid = 1'b0;
        @(negedge clk); lat = 1;
        while (!bus32.out_valid && lat < 200) begin
            if (bus32.in_ready) leak = 1;
            @(negedge clk); lat++;
        end
        if (!bus32.out_valid) tmo = 1;
        if (bus32.in_ready) leak = 1;
        res = bus32.alu_out;
        fl  = {bus32.z_flag, bus32.n_flag, bus32.c_flag, bus32.v_flag};
        bus32.out_ready = 1'b1;
        @(posedge clk); #1 bus32.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [3:0] fl, output int lat,
                           output bit leak, output bit tmo);
        int guard = 0;
        tmo = 0; leak = 0;
        while (!bus16.in_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!bus16.in_ready) tmo = 1;
        bus16.in_valid = 1'b1; bus16.op_sel = op; bus16.in_a = a; bus16.in_b = b;
        @(posedge clk); #1 bus16.in_valid = 1'b0;
        @(negedge clk); lat = 1;
        while (!bus16.out_valid && lat < 200) begin
            if (bus16.in_ready) leak = 1;
            @(negedge clk); lat++;
        end
        if (!bus16.out_valid) tmo = 1;
        if (bus16.in_ready) leak = 1;
        res = bus16.alu_out;
        fl  = {bus16.z_flag, bus16.n_flag, bus16.c_flag, bus16.v_flag};
        bus16.out_ready = 1'b1;
        @(posedge clk); #1 bus16.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r; logic [3:0] f; int l; bit lk, to;
        int seen = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus32.out_valid !== 1'b0 || bus32.alu_out !== 32'd0 ||
            {bus32.z_flag, bus32.n_flag, bus32.c_flag, bus32.v_flag} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_values: out_valid=%b alu_out=%h, want 0/0 with flags 0", bus32.out_valid, bus32.alu_out);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus32.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready);
        end
        // Leave a non-zero result and V flag behind, then reset mid-multiply
        do_op32(4'd1, 32'h8000_0000, 32'd1, r, f, l, lk, to);
        bus32.in_valid = 1'b1; bus32.op_sel = 4'd10; bus32.in_a = 32'h1234; bus32.in_b = 32'h5678;
        @(posedge clk); #1 bus32.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus32.out_valid !== 1'b0 || bus32.alu_out !== 32'd0 ||
            {bus32.z_flag, bus32.n_flag, bus32.c_flag, bus32.v_flag} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_busy: out_valid=%b alu_out=%h flags=%b, want 0/0/0000", bus32.out_valid,
                     bus32.alu_out, {bus32.z_flag, bus32.n_flag, bus32.c_flag, bus32.v_flag});
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", bus32.in_ready, bus32.out_valid);
        end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus32.out_valid) seen++; end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL reset_discard: out_valid high %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_add_sub();
        dvec_t t[3];
        logic [31:0] r; logic [3:0] f; int l; bit lk, to;
        t[0] = '{"add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1,       32'd0,         4'b1010, 1};
        t[1] = '{"sub_ovf",   4'd1,  32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 4'b0001, 1};
        t[2] = '{"reserved",  4'd14, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0,       4'b1000, 1};
        for (int i = 0; i < 3; i++) begin
            do_op32(t[i].op, t[i].a, t[i].b, r, f, l, lk, to);
            vectors++;
            if (r !== t[i].res || f !== t[i].fl || l != t[i].lat || lk || to) begin
                miscompares++;
                $display("FAIL %s: got %h flags %b lat %0d, want %h flags %b lat %0d", t[i].name, r, f, l,
                         t[i].res, t[i].fl, t[i].lat);
            end
        end
    endtask

    task automatic test_cmp_shift();
        dvec_t t[3];
        logic [31:0] r; logic [3:0] f; int l; bit lk, to;
        t[0] = '{"slt",  4'd5, 32'hFFFF_FFFF, 32'd1,     32'd1,         4'b0000, 1};
        t[1] = '{"sltu", 4'd6, 32'hFFFF_FFFF, 32'd1,     32'd0,         4'b1000, 1};
        t[2] = '{"sra",  4'd9, 32'h8000_0000, 32'h21,    32'hC000_0000, 4'b0100, 1};
        for (int i = 0; i < 3; i++) begin
            do_op32(t[i].op, t[i].a, t[i].b, r, f, l, lk, to);
            vectors++;
            if (r !== t[i].res || f !== t[i].fl || l != t[i].lat || lk || to) begin
                miscompares++;
                $display("FAIL %s: got %h flags %b lat %0d, want %h flags %b lat %0d", t[i].name, r, f, l,
                         t[i].res, t[i].fl, t[i].lat);
            end
        end
    endtask

    task automatic test_mul_div();
        dvec_t t[6];
        logic [31:0] r; logic [3:0] f; int l; bit lk, to;
        t[0] = '{"mul",       4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0,         4'b1000, 33};
        t[1] = '{"mulhu",     4'd11, 32'h0001_0000, 32'h0001_0000, 32'd1,         4'b0000, 33};
        t[2] = '{"divu",      4'd12, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
        t[3] = '{"remu",      4'd13, 32'd100,       32'd7,         32'd2,         4'b0000, 33};
        t[4] = '{"divu_zero", 4'd12, 32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF, 4'b0100, 33};
        t[5] = '{"remu_zero", 4'd13, 32'h0000_1234, 32'd0,         32'h0000_1234, 4'b0000, 33};
        for (int i = 0; i < 6; i++) begin
            do_op32(t[i].op, t[i].a, t[i].b, r, f, l, lk, to);
            vectors++;
            if (r !== t[i].res || f !== t[i].fl || l != t[i].lat || lk || to) begin
                miscompares++;
                $display("FAIL %s: got %h flags %b lat %0d ready_leak %0d, want %h flags %b lat %0d",
                         t[i].name, r, f, l, lk, t[i].res, t[i].fl, t[i].lat);
            end
        end
    endtask

    task automatic test_backpressure();
        bus32.in_valid = 1'b1; bus32.op_sel = 4'd0; bus32.in_a = 32'h1234_5678; bus32.in_b = 32'h1111_1111;
        @(posedge clk); #1 bus32.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            // Present a competing op while the result is stalled
            bus32.in_valid = 1'b1; bus32.op_sel = 4'd4; bus32.in_a = 32'hFFFF_0000; bus32.in_b = 32'h1;
            vectors++;
            if (bus32.out_valid !== 1'b1 || bus32.alu_out !== 32'h2345_6789 || bus32.in_ready !== 1'b0 ||
                {bus32.z_flag, bus32.n_flag, bus32.c_flag, bus32.v_flag} !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b out=%h ready=%b, want 1/23456789/0", i,
                         bus32.out_valid, bus32.alu_out, bus32.in_ready);
            end
        end
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        @(posedge clk); #1 bus32.out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1/0", bus32.in_ready, bus32.out_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [3:0] f; int l; bit lk, to;
        int seen = 0;
        bus32.in_valid = 1'b1; bus32.op_sel = 4'd12; bus32.in_a = 32'd100; bus32.in_b = 32'd7;
        @(posedge clk); #1 bus32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy: in_ready=%b out_valid=%b, want 1/0", bus32.in_ready, bus32.out_valid);
        end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus32.out_valid) seen++; end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL flush_drop: out_valid high %0d cycles, want 0", seen);
        end
        // An op offered during flush must be ignored
        flush = 1'b1; bus32.in_valid = 1'b1; bus32.op_sel = 4'd0; bus32.in_a = 32'd1; bus32.in_b = 32'd1;
        @(posedge clk); #1 begin flush = 1'b0; bus32.in_valid = 1'b0; end
        @(negedge clk);
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_priority: in_ready=%b out_valid=%b, want 1/0", bus32.in_ready, bus32.out_valid);
        end
        do_op32(4'd0, 32'd2, 32'd3, r, f, l, lk, to);
        vectors++;
        if (r !== 32'd5 || f !== 4'b0000 || l != 1 || to) begin
            miscompares++; $display("FAIL flush_recover: got %h lat %0d, want 5 lat 1", r, l);
        end
    endtask

    task automatic test_back_to_back();
        int rdy = 0, vld = 0, bad = 0;
        bus32.in_valid = 1'b1; bus32.op_sel = 4'd0; bus32.in_a = 32'd5; bus32.in_b = 32'd6;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus32.in_ready) rdy++;
            if (bus32.out_valid) begin vld++; if (bus32.alu_out !== 32'd11) bad++; end
        end
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        vectors++;
        if (rdy != 10 || vld != 10 || bad != 0) begin
            miscompares++;
            $display("FAIL back_to_back: ready %0d valid %0d bad %0d, want 10/10/0", rdy, vld, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_random32(input int n);
        logic [3:0] op, f, ef; longint unsigned a, b, er; logic [31:0] r; int l, el; bit lk, to;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(32); b = pick(32);
            ref_op(32, op, a, b, er, ef, el);
            do_op32(op, a[31:0], b[31:0], r, f, l, lk, to);
            vectors++;
            if (r !== er[31:0] || f !== ef || l != el || lk || to) begin
                miscompares++;
                $display("FAIL rand32[%0d] op=%0d a=%h b=%h: got %h flags %b lat %0d, want %h flags %b lat %0d",
                         i, op, a[31:0], b[31:0], r, f, l, er[31:0], ef, el);
            end
        end
    endtask

    task automatic test_random16(input int n);
        logic [3:0] op, f, ef; longint unsigned a, b, er; logic [15:0] r; int l, el; bit lk, to;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick(16); b = pick(16);
            ref_op(16, op, a, b, er, ef, el);
            do_op16(op, a[15:0], b[15:0], r, f, l, lk, to);
            vectors++;
            if (r !== er[15:0] || f !== ef || l != el || lk || to) begin
                miscompares++;
                $display("FAIL rand16[%0d] op=%0d a=%h b=%h: got %h flags %b lat %0d, want %h flags %b lat %0d",
                         i, op, a[15:0], b[15:0], r, f, l, er[15:0], ef, el);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.op_sel = '0; bus32.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.op_sel = '0; bus16.out_ready = 1'b0;
        test_reset();
        test_add_sub();
        test_cmp_shift();
        test_mul_div();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random32(1000);
        test_random16(1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
Parametrised, sequential successor to the single-cycle CPU ALU. Operands are accepted through a valid/ready handshake. Most operations complete in one registered cycle. Multiply and divide use an iterative shift-add / restoring-divide datapath. Sits in the CPU execute stage; the control unit stalls on in_ready/out_valid, and the ALU publishes Z/N/C/V flags with every result.

Parameters:
DATA_WIDTH, 32, operand/result width; must be >= 8 and a power of 2
SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort: drop the in-flight op and any held result
in_valid  input  1  operands and op_sel valid
in_ready  output  1  ALU can accept an op this cycle
in_a  input  DATA_WIDTH  operand A
in_b  input  DATA_WIDTH  operand B / shift amount
op_sel  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14-15 reserved
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes the result
alu_out  output  DATA_WIDTH  result
z_flag  output  1  result == 0
n_flag  output  1  alu_out[DATA_WIDTH-1]
c_flag  output  1  ADD: carry-out; SUB: borrow (a < b unsigned); 0 for all other ops
v_flag  output  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0, alu_out=0, all flags=0, in_ready=1 once rst deasserts; internal iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). An op is accepted on a rising edge with in_valid & in_ready; operands are captured at that edge.
- Single-cycle ops (0-9, 14, 15): IDLE -> DONE. out_valid rises the cycle after acceptance (latency 1).
- Iterative ops (10-13): IDLE -> BUSY for exactly DATA_WIDTH cycles, then DONE. out_valid rises DATA_WIDTH+1 cycles after acceptance.
- DONE: alu_out and flags are held stable while out_valid=1 and out_ready=0. On out_valid & out_ready, go to IDLE. No new op is accepted in the same cycle; back-to-back throughput is one op per 2 cycles minimum.
- flush=1 (synchronous, priority over all other inputs): state -> IDLE, out_valid -> 0, counter -> 0. alu_out and flags are not required to clear. Any op presented the same cycle is not accepted.
- rst mid-BUSY: immediate return to reset values; the partial result is discarded.
- Arithmetic width rules:
  - ADD/SUB are computed at DATA_WIDTH+1 bits to derive C.
  - V = (a_msb == b_eff_msb) && (res_msb != a_msb), with b_eff = ~b for SUB.
  - SLT is signed compare; SLTU is unsigned; both return 0 or 1 zero-extended.
  - Shifts use in_b[SHAMT_W-1:0]; upper bits of in_b are ignored. SRA sign-fills.
  - MUL returns the low DATA_WIDTH bits of the unsigned product; MULHU returns the high DATA_WIDTH bits.
- Divide by zero (in_b==0): DIVU returns all ones; REMU returns in_a. Still takes DATA_WIDTH cycles. No exception.
- Reserved opcodes: alu_out=0, z_flag=1, other flags 0, latency 1.
- z_flag and n_flag are evaluated on the final alu_out for every op.

Test Plan:
- Reset: assert rst mid-BUSY of a MUL -> out_valid=0, alu_out=0, flags 0 immediately; in_ready=1 the cycle after rst drops.
- ADD 0xFFFF_FFFF + 0x0000_0001 -> alu_out=0, z=1, c=1, v=0, n=0, out_valid 1 cycle after accept. SUB 0x8000_0000 - 1 -> 0x7FFF_FFFF, v=1, c=0.
- SLT 0xFFFF_FFFF vs 1 -> 1; SLTU same operands -> 0. SRA 0x8000_0000 by in_b=0x21 -> shift 1 -> 0xC000_0000.
- MUL 0x0001_0000 * 0x0001_0000 -> 0; MULHU same operands -> 0x0000_0001. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU 100/7 -> 14, REMU -> 2. DIVU x/0 -> 0xFFFF_FFFF; REMU 0x1234/0 -> 0x1234.
- Backpressure and flush: hold out_ready=0 for 5 cycles -> result stable and in_ready=0. flush at BUSY cycle 10 of DIVU -> out_valid never rises, in_ready=1 next cycle. Finish with 1000 random ops against a reference model at DATA_WIDTH=32 and 16, requiring 0 mismatches.
